// File: rtl/maze_pkg.sv
// Shared definitions for the depth-first maze controller.
//
// Contents:
//   DIR_*      2-bit move directions (up, right, down, left); the opposite
//              of any direction is dir ^ 2'b10.
//   state_t    controller state encoding.
//   step_t     result of a single move: neighbour coordinates plus an
//              underflow flag.
//   next_xy()  applies one move to a coordinate pair.
package maze_pkg;

    // Width used for coordinate arithmetic inside next_xy. It is wider than
    // any supported N, so a step past the far edge shows up as a value above
    // the maze limit instead of wrapping back into range.
    localparam int CW = 16;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHK0,
        ST_CHK0S,
        ST_MARK,
        ST_PICK,
        ST_READ,
        ST_CHECK,
        ST_BACK,
        ST_DONE,
        ST_RPL,
        ST_FAIL,
        ST_DONE_IDLE
    } state_t;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          oob;
    } step_t;

    // oob only reports a step below zero. The function does not know the
    // maze size, so the caller rejects results beyond its own far edge.
    function automatic step_t next_xy(input logic [CW-1:0] x,
                                      input logic [CW-1:0] y,
                                      input logic [1:0]    dir);
        step_t s;
        s.x   = x;
        s.y   = y;
        s.oob = 1'b0;
        case (dir)
            DIR_UP: begin
                s.oob = (y == '0);
                s.y   = y - CW'(1);
            end
            DIR_RIGHT: s.x = x + CW'(1);
            DIR_DOWN:  s.y = y + CW'(1);
            DIR_LEFT: begin
                s.oob = (x == '0);
                s.x   = x - CW'(1);
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dir_stack.sv
// Path stack of 2-bit move directions.
//
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset of the stack pointer
//   clear       empty the stack (sp <= 0) at the start of a run
//   push        write push_dir at sp and increment sp
//   pop         decrement sp (top_dir shows the entry being removed)
//   push_dir    direction to push
//   rd_idx      independent read index used for path replay
//   top_dir     entry at sp-1
//   rd_dir      entry at rd_idx
//   sp          current stack depth = number of moves on the path
module dir_stack #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    push_dir,
    input  logic [AW-1:0] rd_idx,
    output logic [1:0]    top_dir,
    output logic [1:0]    rd_dir,
    output logic [AW-1:0] sp
);

    // Entries are data only; they are meaningless below sp and need no reset.
    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp] <= push_dir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + AW'(1);
        end else if (pop) begin
            sp <= sp - AW'(1);
        end
    end

    assign top_dir = mem[sp - AW'(1)];
    assign rd_dir  = mem[rd_idx];

endmodule

// File: rtl/maze_dfs_ctrl.sv
// Depth-first maze solver driving a single-bit maze memory.
//
// Searches from (0,0) to (2^N-1, 2^N-1), marking every visited cell by
// writing 1 into the memory, keeps the current path as a stack of move
// directions and, on success, replays the path one cell per cycle.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   start                 begin a run (accepted only in IDLE / DONE_IDLE)
//   X, Y                  memory column / row address
//   D_in                  memory write data (1 whenever WR is high)
//   RD                    read strobe; D_out is valid the following cycle
//   WR                    write strobe; write happens at the same clock edge
//   D_out                 memory read data: 0 free, 1 wall or visited
//   busy                  search in progress
//   done, fail            result levels, held until the next accepted start
//   path_len              number of moves on the found path
//   path_valid            replay strobe, one cycle per path cell
//   path_x, path_y        replayed cell
module maze_dfs_ctrl
    import maze_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 2 ** (2 * N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [N-1:0]   X,
    output logic [N-1:0]   Y,
    output logic           D_in,
    output logic           RD,
    output logic           WR,
    input  logic           D_out,
    output logic           busy,
    output logic           done,
    output logic           fail,
    output logic [2*N-1:0] path_len,
    output logic           path_valid,
    output logic [N-1:0]   path_x,
    output logic [N-1:0]   path_y
);

    localparam int            SPW = 2 * N;
    localparam logic [CW-1:0] LIM = CW'((1 << N) - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [N-1:0]   nbr_x_q, nbr_x_d, nbr_y_q, nbr_y_d;
    logic [N-1:0]   rpl_x_q, rpl_x_d, rpl_y_q, rpl_y_d;
    logic [SPW-1:0] rpl_k_q, rpl_k_d;
    logic [SPW-1:0] len_q, len_d;
    logic [2:0]     dir_q, dir_d;
    logic           busy_q, busy_d, done_q, done_d, fail_q, fail_d;

    logic           stk_clear, stk_push, stk_pop;
    logic [1:0]     stk_top, stk_rd;
    logic [SPW-1:0] sp;

    logic [N-1:0]   step_x, step_y;
    logic [1:0]     step_dir;
    step_t          step_s;
    logic           step_oob;

    dir_stack #(
        .DEPTH (DEPTH),
        .AW    (SPW)
    ) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (stk_clear),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_dir (dir_q[1:0]),
        .rd_idx   (rpl_k_q),
        .top_dir  (stk_top),
        .rd_dir   (stk_rd),
        .sp       (sp)
    );

    // One shared stepper: PICK probes cur+dir, BACK retraces cur by the
    // opposite of the popped move, replay advances the replay cursor.
    always_comb begin
        step_x   = cur_x_q;
        step_y   = cur_y_q;
        step_dir = dir_q[1:0];
        if (state_q == ST_BACK) begin
            step_dir = stk_top ^ 2'b10;
        end else if (state_q == ST_DONE || state_q == ST_RPL) begin
            step_x   = rpl_x_q;
            step_y   = rpl_y_q;
            step_dir = stk_rd;
        end
    end

    assign step_s   = next_xy(CW'(step_x), CW'(step_y), step_dir);
    assign step_oob = step_s.oob | (step_s.x > LIM) | (step_s.y > LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_x_q <= '0;
            cur_y_q <= '0;
            nbr_x_q <= '0;
            nbr_y_q <= '0;
            rpl_x_q <= '0;
            rpl_y_q <= '0;
            rpl_k_q <= '0;
            len_q   <= '0;
            dir_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            nbr_x_q <= nbr_x_d;
            nbr_y_q <= nbr_y_d;
            rpl_x_q <= rpl_x_d;
            rpl_y_q <= rpl_y_d;
            rpl_k_q <= rpl_k_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    // Memory strobes and addresses depend on registered state only, so they
    // are stable for the whole strobe cycle.
    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        nbr_x_d    = nbr_x_q;
        nbr_y_d    = nbr_y_q;
        rpl_x_d    = rpl_x_q;
        rpl_y_d    = rpl_y_q;
        rpl_k_d    = rpl_k_q;
        len_d      = len_q;
        dir_d      = dir_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fail_d     = fail_q;
        stk_clear  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        X          = '0;
        Y          = '0;
        RD         = 1'b0;
        WR         = 1'b0;
        path_valid = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE_IDLE: begin
                if (start) begin
                    state_d   = ST_CHK0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    len_d     = '0;
                    cur_x_d   = '0;
                    cur_y_d   = '0;
                    dir_d     = '0;
                    rpl_x_d   = '0;
                    rpl_y_d   = '0;
                    rpl_k_d   = '0;
                    stk_clear = 1'b1;
                end
            end

            ST_CHK0: begin
                RD      = 1'b1;
                X       = cur_x_q;
                Y       = cur_y_q;
                state_d = ST_CHK0S;
            end

            ST_CHK0S: begin
                if (D_out) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    len_d   = '0;
                end else begin
                    state_d = ST_MARK;
                end
            end

            ST_MARK: begin
                WR = 1'b1;
                X  = cur_x_q;
                Y  = cur_y_q;
                if (cur_x_q == LIM[N-1:0] && cur_y_q == LIM[N-1:0]) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    len_d   = sp;
                    rpl_x_d = '0;
                    rpl_y_d = '0;
                    rpl_k_d = '0;
                end else begin
                    dir_d   = '0;
                    state_d = ST_PICK;
                end
            end

            ST_PICK: begin
                if (dir_q == 3'd4) begin
                    state_d = ST_BACK;
                end else if (step_oob) begin
                    dir_d = dir_q + 3'd1;
                end else begin
                    nbr_x_d = step_s.x[N-1:0];
                    nbr_y_d = step_s.y[N-1:0];
                    state_d = ST_READ;
                end
            end

            ST_READ: begin
                RD      = 1'b1;
                X       = nbr_x_q;
                Y       = nbr_y_q;
                state_d = ST_CHECK;
            end

            ST_CHECK: begin
                if (D_out) begin
                    dir_d   = dir_q + 3'd1;
                    state_d = ST_PICK;
                end else begin
                    stk_push = 1'b1;
                    cur_x_d  = nbr_x_q;
                    cur_y_d  = nbr_y_q;
                    state_d  = ST_MARK;
                end
            end

            ST_BACK: begin
                if (sp == '0) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    len_d   = '0;
                end else begin
                    // Resume the parent cell at the direction after the one
                    // that led into the dead end.
                    stk_pop = 1'b1;
                    cur_x_d = step_s.x[N-1:0];
                    cur_y_d = step_s.y[N-1:0];
                    dir_d   = {1'b0, stk_top} + 3'd1;
                    state_d = ST_PICK;
                end
            end

            ST_DONE, ST_RPL: begin
                // Replay cell k is the start cell after the first k moves.
                path_valid = 1'b1;
                if (rpl_k_q == sp) begin
                    state_d = ST_DONE_IDLE;
                end else begin
                    rpl_x_d = step_s.x[N-1:0];
                    rpl_y_d = step_s.y[N-1:0];
                    rpl_k_d = rpl_k_q + SPW'(1);
                    state_d = ST_RPL;
                end
            end

            ST_FAIL: begin
                state_d = ST_DONE_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign D_in     = WR;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign path_len = len_q;
    assign path_x   = path_valid ? rpl_x_q : '0;
    assign path_y   = path_valid ? rpl_y_q : '0;

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
module tb_maze_dfs_ctrl;

    localparam int N = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   X, Y, path_x, path_y;
    logic           D_in, RD, WR, busy, done, fail, path_valid;
    logic           D_out = 1'b0;
    logic [2*N-1:0] path_len;

    // Maze memory model: bit index = y*16 + x.
    logic [255:0] mem = '0;
    logic [255:0] img = '0;
    logic         load = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    int rec_x[$], rec_y[$], exp_x[$], exp_y[$];
    int wr_cnt, done_cyc, fail_cyc;

    always #5 clk = ~clk;

    maze_dfs_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .X          (X),
        .Y          (Y),
        .D_in       (D_in),
        .RD         (RD),
        .WR         (WR),
        .D_out      (D_out),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .path_len   (path_len),
        .path_valid (path_valid),
        .path_x     (path_x),
        .path_y     (path_y)
    );

    always @(posedge clk) begin
        if (load) mem <= img;
        else if (WR) mem[{Y, X}] <= D_in;
        if (RD) D_out <= mem[{Y, X}];
    end

    function automatic int idx(input int x, input int y);
        return y * 16 + x;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_img();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    // Pulse start, then watch until the result (and any replay) is over.
    // poke_a: cycle at which start is pulsed again (-1 = never);
    // poke_b: cycles after done at which start is pulsed (<=0 = never).
    task automatic run(input int budget, input int poke_a, input int poke_b);
        bit timed_out;
        rec_x.delete();
        rec_y.delete();
        wr_cnt    = 0;
        done_cyc  = -1;
        fail_cyc  = -1;
        timed_out = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (WR) wr_cnt++;
            if (path_valid) begin
                rec_x.push_back(int'(path_x));
                rec_y.push_back(int'(path_y));
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (fail && fail_cyc < 0) fail_cyc = cyc;
            if ((fail_cyc >= 0 && cyc > fail_cyc + 2) ||
                (done_cyc >= 0 && !path_valid && cyc > done_cyc)) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
            start = (cyc + 1 == poke_a) || (poke_b > 0 && done_cyc >= 0 && cyc + 1 == done_cyc + poke_b);
        end
        start = 1'b0;
        check("run_timeout", 32'(timed_out), 0);
    endtask

    task automatic check_path(input string tag);
        check({tag, "_cells"}, 32'(rec_x.size()), 32'(exp_x.size()));
        for (int i = 0; i < exp_x.size() && i < rec_x.size(); i++)
            check($sformatf("%s_cell%0d", tag, i), 32'(rec_x[i] * 100 + rec_y[i]),
                  32'(exp_x[i] * 100 + exp_y[i]));
    endtask

    task automatic exp_zero();
        exp_x.delete(); exp_y.delete();
        for (int x = 0; x < 16; x++) begin exp_x.push_back(x); exp_y.push_back(0); end
        for (int y = 1; y < 16; y++) begin exp_x.push_back(15); exp_y.push_back(y); end
    endtask

    task automatic exp_corr();
        exp_x.delete(); exp_y.delete();
        for (int y = 0; y < 16; y++) begin exp_x.push_back(0); exp_y.push_back(y); end
        for (int x = 1; x < 16; x++) begin exp_x.push_back(x); exp_y.push_back(15); end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_X"}, 32'(X), 0);
        check({tag, "_Y"}, 32'(Y), 0);
        check({tag, "_RD"}, 32'(RD), 0);
        check({tag, "_WR"}, 32'(WR), 0);
        check({tag, "_D_in"}, 32'(D_in), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_fail"}, 32'(fail), 0);
        check({tag, "_path_len"}, 32'(path_len), 0);
        check({tag, "_path_valid"}, 32'(path_valid), 0);
        check({tag, "_path_x"}, 32'(path_x), 0);
        check({tag, "_path_y"}, 32'(path_y), 0);
    endtask

    initial begin
        int bad_step, bad_row0, dx, dy;

        // Reset values
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Open maze: right along row 0, then down column 15
        img = '0;
        load_img();
        run(2000, -1, 0);
        check("open_done", 32'(done), 1);
        check("open_fail", 32'(fail), 0);
        check("open_len", 32'(path_len), 30);
        exp_zero();
        check_path("open");

        // Start cell blocked
        img = '0;
        img[idx(0, 0)] = 1'b1;
        load_img();
        run(100, -1, 0);
        check("blocked_fail", 32'(fail), 1);
        check("blocked_done", 32'(done), 0);
        check("blocked_latency_le3", 32'(fail_cyc >= 0 && fail_cyc <= 3), 1);
        check("blocked_wr_count", 32'(wr_cnt), 0);
        check("blocked_len", 32'(path_len), 0);
        check("blocked_replay", 32'(rec_x.size()), 0);

        // Goal walled in: full exploration then fail
        img = '0;
        img[idx(14, 15)] = 1'b1;
        img[idx(15, 14)] = 1'b1;
        load_img();
        run(20000, -1, 0);
        check("walled_fail", 32'(fail), 1);
        check("walled_done", 32'(done), 0);
        check("walled_len", 32'(path_len), 0);
        check("walled_marked", 32'($countones(mem)), 255);
        check("walled_goal_free", 32'(mem[idx(15, 15)]), 0);

        // Dead-end corridor along row 0 forces a backtrack to (0,0)
        img = '1;
        for (int x = 0; x < 6; x++)  img[idx(x, 0)]  = 1'b0;
        for (int y = 0; y < 16; y++) img[idx(0, y)]  = 1'b0;
        for (int x = 0; x < 16; x++) img[idx(x, 15)] = 1'b0;
        load_img();
        run(5000, -1, 0);
        check("corr_done", 32'(done), 1);
        check("corr_len", 32'(path_len), 30);
        exp_corr();
        check_path("corr");
        bad_step = 0;
        bad_row0 = 0;
        for (int i = 0; i < rec_x.size(); i++) begin
            if (rec_y[i] == 0 && rec_x[i] > 0) bad_row0++;
            if (i > 0) begin
                dx = rec_x[i] - rec_x[i-1];
                dy = rec_y[i] - rec_y[i-1];
                if ((dx * dx + dy * dy) != 1) bad_step++;
            end
        end
        check("corr_row0_cells", 32'(bad_row0), 0);
        check("corr_bad_steps", 32'(bad_step), 0);

        // start pulsed while busy and during replay is ignored
        img = '0;
        load_img();
        run(2000, 10, 5);
        check("poke_done", 32'(done), 1);
        check("poke_len", 32'(path_len), 30);
        exp_zero();
        check_path("poke");

        // Asynchronous reset in the middle of a search
        img = '0;
        load_img();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        img = '0;
        load_img();
        run(2000, -1, 0);
        check("after_rst_done", 32'(done), 1);
        check("after_rst_len", 32'(path_len), 30);
        exp_zero();
        check_path("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
